// File: rtl/stop_watch_pkg.sv
// Shared types and constants for the stopwatch control machine and counter.
package stop_watch_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [1:0] dig_idx_t;

  typedef enum logic {
    DISP_SEC_CSEC = 1'b0,
    DISP_MIN_SEC  = 1'b1
  } disp_mode_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int         CSEC_MAX  = 99;
  localparam int         SEC_MAX   = 59;
  localparam int         MIN_MAX   = 59;

  // Full count, most significant digit first.
  typedef struct packed {
    bcd_t min_t;
    bcd_t min_o;
    bcd_t sec_t;
    bcd_t sec_o;
    bcd_t csec_t;
    bcd_t csec_o;
  } cnt_t;

  // Increment a two-digit BCD field that rolls over after max; returns {carry, tens, ones}.
  function automatic logic [8:0] bcd_pair_inc(input bcd_t tens, input bcd_t ones, input int max);
    bcd_t max_t;
    bcd_t max_o;
    max_t = bcd_t'(max / 10);
    max_o = bcd_t'(max % 10);
    if (tens == max_t && ones == max_o)
      return {1'b1, 8'h00};
    else if (ones == 4'd9)
      return {1'b0, tens + 4'd1, 4'd0};
    else
      return {1'b0, tens, ones + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-low {g,f,e,d,c,b,a} segments; values A-F blank.
// Latency: combinational. Backpressure: none.
module bcd_to_7seg
  import stop_watch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stop_watch_counter.sv
// BCD min/sec/csec stopwatch count with a multiplexed active-low 4-digit display.
// Latency: counters 2 clk after pls_100hz rise, disp_bcd +1 clk, scan outputs on next scan step.
// Backpressure: none; cnt_en/clr_plso are only honoured on the tick cycle.
module stop_watch_counter
  import stop_watch_pkg::*;
#(
  parameter int SCAN_DIV = 31250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pls_100hz,
  input  logic        cnt_en,
  input  logic        clr_plso,
  input  logic        disp_mode,
  output logic [7:0]  csec_bcd,
  output logic [7:0]  sec_bcd,
  output logic [7:0]  min_bcd,
  output logic [15:0] disp_bcd,
  output logic        wrap_flag,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int                DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic             p0, p1, tick;
  cnt_t             cnt_q, cnt_nxt;
  logic             wrap_q, wrap_nxt;
  logic             c_csec, c_sec, c_min;
  logic [DIV_W-1:0] div_q;
  dig_idx_t         idx_q;
  logic             scan_step;
  bcd_t             scan_nib;
  logic [6:0]       seg_dec;
  logic [3:0]       an_nxt;
  logic             dp_nxt;

  assign tick = p0 & ~p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      p0 <= 1'b0;
      p1 <= 1'b0;
    end else begin
      p0 <= pls_100hz;
      p1 <= p0;
    end
  end

  always_comb begin
    cnt_nxt  = cnt_q;
    wrap_nxt = wrap_q;
    c_csec   = 1'b0;
    c_sec    = 1'b0;
    c_min    = 1'b0;
    if (tick) begin
      if (clr_plso) begin
        cnt_nxt  = '0;
        wrap_nxt = 1'b0;
      end else if (cnt_en) begin
        {c_csec, cnt_nxt.csec_t, cnt_nxt.csec_o} = bcd_pair_inc(cnt_q.csec_t, cnt_q.csec_o, CSEC_MAX);
        if (c_csec) begin
          {c_sec, cnt_nxt.sec_t, cnt_nxt.sec_o} = bcd_pair_inc(cnt_q.sec_t, cnt_q.sec_o, SEC_MAX);
          if (c_sec) begin
            {c_min, cnt_nxt.min_t, cnt_nxt.min_o} = bcd_pair_inc(cnt_q.min_t, cnt_q.min_o, MIN_MAX);
            if (c_min)
              wrap_nxt = 1'b1;
          end
        end
      end
    end
  end

  // Loaded every cycle so the hold path goes through cnt_nxt as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign csec_bcd  = {cnt_q.csec_t, cnt_q.csec_o};
  assign sec_bcd   = {cnt_q.sec_t, cnt_q.sec_o};
  assign min_bcd   = {cnt_q.min_t, cnt_q.min_o};
  assign wrap_flag = wrap_q;

  always_ff @(posedge clk) begin
    if (rst)
      disp_bcd <= '0;
    else if (disp_mode == DISP_MIN_SEC)
      disp_bcd <= {min_bcd, sec_bcd};
    else
      disp_bcd <= {sec_bcd, csec_bcd};
  end

  assign scan_step = (div_q == DIV_LAST);

  always_comb begin
    case (idx_q)
      2'd0:    scan_nib = disp_bcd[15:12];
      2'd1:    scan_nib = disp_bcd[11:8];
      2'd2:    scan_nib = disp_bcd[7:4];
      default: scan_nib = disp_bcd[3:0];
    endcase
  end

  bcd_to_7seg u_dec (
    .bcd (scan_nib),
    .seg (seg_dec)
  );

  // Point sits after the second digit; in min.sec view it blinks at 1 Hz.
  always_comb begin
    an_nxt = ~(4'b1000 >> idx_q);
    dp_nxt = ~((idx_q == 2'd1) &&
               ((disp_mode == DISP_SEC_CSEC) || (cnt_q.csec_t < 4'd5)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
      an    <= 4'b1111;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      div_q <= scan_step ? '0 : div_q + 1'b1;
      if (scan_step) begin
        idx_q <= idx_q + 2'd1;
        an    <= an_nxt;
        seg   <= seg_dec;
        dp    <= dp_nxt;
      end
    end
  end

endmodule
